// File: rtl/table_loader_pkg.sv
// Shared definitions for the routing-table loader: FSM encodings and width helpers.
package table_loader_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Never returns less than 1 so single-router builds still get a legal index width.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int dest_bits(input int size);
      return size - 1;
   endfunction

   function automatic int dests(input int size);
      return 1 << (size - 1);
   endfunction

endpackage

// File: rtl/table_loader_table_store.sv
// Shared routing-table RAM: one synchronous write port, one combinational read port.
module table_store #(
   parameter int AW = 9,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/table_loader.sv
// Routing-table preload scheduler: releases routers one at a time and steers the store to the active one.
// Optional load watchdog enabled by defining TABLE_LOADER_TIMEOUT_EN.
//
//  state | meaning
//  IDLE  | store writable, all routers held in reset, waiting for start
//  LOAD  | router `active` released and reading its table through the store
//  DONE  | every router loaded; waits for start to re-arm
module table_loader
   import table_loader_pkg::*;
#(
   parameter int ROUTERS       = 4,
   parameter int PORT_BITS     = 8,
   parameter int SIZE          = 8,
   parameter int TIMEOUT_SLACK = 4,
   localparam int DB           = dest_bits(SIZE),
   localparam int RW           = clog2(ROUTERS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cfg_we,
   input  logic [RW-1:0]          cfg_router,
   input  logic [DB-1:0]          cfg_addr,
   input  logic [PORT_BITS-1:0]   cfg_data,
   output logic                   cfg_err,
   input  logic                   start,
   output logic [ROUTERS-1:0]     rtr_reset,
   input  logic [ROUTERS*DB-1:0]  rtr_table_addr,
   output logic [ROUTERS*PORT_BITS-1:0] rtr_table_data,
   input  logic [ROUTERS-1:0]     rtr_ready,
   output logic                   busy,
   output logic                   done,
   output logic [ROUTERS-1:0]     err_flags
);

   localparam int DESTS = dests(SIZE);
   localparam int AW    = RW + DB;

   logic [1:0]           state;
   logic [RW-1:0]        active;
   logic [RW-1:0]        next_active;
   logic                 ready_act;
   logic                 timeout;
   logic                 advance;
   logic                 last;
   logic                 store_we;
   logic [AW-1:0]        store_raddr;
   logic [PORT_BITS-1:0] store_rdata;

   assign next_active = active + 1'b1;
   assign ready_act   = rtr_ready[active];
   assign last        = (active == RW'(ROUTERS - 1));
   assign advance     = (state == ST_LOAD) && (ready_act || timeout);
   assign busy        = (state == ST_LOAD);

   assign store_we    = cfg_we && (state == ST_IDLE);
   assign store_raddr = {active, rtr_table_addr[int'(active)*DB +: DB]};

   table_store #(
      .AW (AW),
      .DW (PORT_BITS)
   ) u_store (
      .clk   (clk),
      .we    (store_we),
      .waddr ({cfg_router, cfg_addr}),
      .wdata (cfg_data),
      .raddr (store_raddr),
      .rdata (store_rdata)
   );

   // Only the router currently being loaded sees table data; everyone else reads zero.
   always_comb begin
      rtr_table_data = '0;
      if (state == ST_LOAD) rtr_table_data[int'(active)*PORT_BITS +: PORT_BITS] = store_rdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         active    <= '0;
         rtr_reset <= '1;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         cfg_err <= cfg_we && (state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state        <= ST_LOAD;
                  active       <= '0;
                  rtr_reset[0] <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (advance) begin
                  if (last) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     active                 <= next_active;
                     rtr_reset[next_active] <= 1'b0;
                  end
               end
            end
            ST_DONE: begin
               if (start) begin
                  state     <= ST_IDLE;
                  rtr_reset <= '1;
                  done      <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef TABLE_LOADER_TIMEOUT_EN
   localparam int TC = DESTS + TIMEOUT_SLACK;
   localparam int CW = clog2(TC + 1);

   logic [CW-1:0]      slot_cnt;
   logic [ROUTERS-1:0] err_q;

   assign timeout   = (state == ST_LOAD) && !ready_act && (slot_cnt == CW'(TC));
   assign err_flags = err_q;

   // Slot counter restarts on every slot entry; err_q survives re-arm and only clears on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_cnt <= '0;
         err_q    <= '0;
      end else if (state == ST_IDLE) begin
         if (start) slot_cnt <= '0;
      end else if (state == ST_LOAD) begin
         if (advance) slot_cnt <= '0;
         else         slot_cnt <= slot_cnt + 1'b1;
         if (timeout) err_q[active] <= 1'b1;
      end
   end
`else
   localparam int UNUSED_SLACK = TIMEOUT_SLACK + DESTS;

   assign timeout   = 1'b0;
   assign err_flags = '0;
`endif

endmodule

// File: tb/tb_table_loader.sv
// Scoreboard bench for table_loader; define TABLE_LOADER_TIMEOUT_EN to also exercise the watchdog.
module tb_table_loader;

   localparam int ROUTERS   = 4;
   localparam int PORT_BITS = 8;
   localparam int SIZE      = 8;
   localparam int SLACK     = 4;
   localparam int DB        = SIZE - 1;
   localparam int DESTS     = 1 << DB;
   localparam int SLOT      = DESTS + 1;

   logic                         clk = 1'b0;
   logic                         reset = 1'b1;
   logic                         cfg_we = 1'b0;
   logic [1:0]                   cfg_router = '0;
   logic [DB-1:0]                cfg_addr = '0;
   logic [PORT_BITS-1:0]         cfg_data = '0;
   logic                         cfg_err;
   logic                         start = 1'b0;
   logic [ROUTERS-1:0]           rtr_reset;
   logic [ROUTERS*DB-1:0]        rtr_table_addr;
   logic [ROUTERS*PORT_BITS-1:0] rtr_table_data;
   logic [ROUTERS-1:0]           rtr_ready;
   logic                         busy;
   logic                         done;
   logic [ROUTERS-1:0]           err_flags;

   always #5 clk = ~clk;

   table_loader #(
      .ROUTERS       (ROUTERS),
      .PORT_BITS     (PORT_BITS),
      .SIZE          (SIZE),
      .TIMEOUT_SLACK (SLACK)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .cfg_we         (cfg_we),
      .cfg_router     (cfg_router),
      .cfg_addr       (cfg_addr),
      .cfg_data       (cfg_data),
      .cfg_err        (cfg_err),
      .start          (start),
      .rtr_reset      (rtr_reset),
      .rtr_table_addr (rtr_table_addr),
      .rtr_table_data (rtr_table_data),
      .rtr_ready      (rtr_ready),
      .busy           (busy),
      .done           (done),
      .err_flags      (err_flags)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: what the store should hold, and how long each slot should last.
   logic [PORT_BITS-1:0] ref_mem [ROUTERS][DESTS];
   int                   slot_len [ROUTERS];
   bit                   load_on = 1'b0;
   int                   ld_s = 0;

   typedef struct { int idx; int edge_n; } ev_t;
   ev_t rel_q [$];
   int  done_q [$];
   int  err_q [$];

   // Router models: sweep addresses 0..DESTS-1 after release, then raise ready.
   int                   cnt [ROUTERS];
   logic [DB-1:0]        rnd [ROUTERS];
   logic [PORT_BITS-1:0] cap [ROUTERS][DESTS];
   logic [ROUTERS-1:0]   rdy;
   logic [ROUTERS-1:0]   hold_low = '0;

   always @(posedge clk) begin
      for (int k = 0; k < ROUTERS; k++) begin
         rnd[k] <= DB'($urandom);
         if (rtr_reset[k] !== 1'b0) begin
            cnt[k] <= 0;
            rdy[k] <= 1'b0;
         end else if (cnt[k] < DESTS) begin
            cap[k][cnt[k]] <= rtr_table_data[k*PORT_BITS +: PORT_BITS];
            cnt[k]         <= cnt[k] + 1;
            if (cnt[k] == DESTS - 1 && !hold_low[k]) rdy[k] <= 1'b1;
         end
      end
   end

   assign rtr_ready = rdy;

   always_comb begin
      rtr_table_addr = '0;
      for (int k = 0; k < ROUTERS; k++) begin
         rtr_table_addr[k*DB +: DB] = (rtr_reset[k] === 1'b0 && cnt[k] < DESTS) ? DB'(cnt[k]) : rnd[k];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int exp_active(input int off);
      int acc;
      acc = 0;
      for (int k = 0; k < ROUTERS; k++) begin
         if (off < acc + slot_len[k]) return k;
         acc += slot_len[k];
      end
      return -1;
   endfunction

   // Monitor: pops expected events as the DUT shows them and checks steering every cycle.
   initial begin
      logic [ROUTERS-1:0]           prev_rst;
      logic                         prev_done;
      logic [ROUTERS*PORT_BITS-1:0] expd;
      int                           a;
      ev_t                          ev;
      int                           en;
      prev_rst  = '1;
      prev_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < ROUTERS; k++) begin
            if (prev_rst[k] === 1'b1 && rtr_reset[k] === 1'b0) begin
               if (rel_q.size() == 0) check($sformatf("unexpected_release_r%0d", k), 1, 0);
               else begin
                  ev = rel_q.pop_front();
                  check("release_router", k, ev.idx);
                  check($sformatf("release_edge_r%0d", k), cyc, ev.edge_n);
               end
            end
         end
         if (done === 1'b1 && prev_done !== 1'b1) begin
            if (done_q.size() == 0) check("unexpected_done", 1, 0);
            else begin
               en = done_q.pop_front();
               check("done_edge", cyc, en);
            end
         end
         if (cfg_err !== 1'b0) begin
            if (err_q.size() == 0) check("unexpected_cfg_err", cfg_err, 0);
            else begin
               en = err_q.pop_front();
               check("cfg_err_edge", cyc, en);
            end
         end
         a = (load_on && cyc >= ld_s) ? exp_active(cyc - ld_s) : -1;
         expd = '0;
         if (a >= 0) expd[a*PORT_BITS +: PORT_BITS] = ref_mem[a][rtr_table_addr[a*DB +: DB]];
         check("steer_data", rtr_table_data, expd);
         check("busy", busy, (a >= 0));
         prev_rst  = rtr_reset;
         prev_done = done;
      end
   end

   // All stimulus tasks are entered just after a falling edge.
   task automatic cfg_write(input int r, input int a, input logic [PORT_BITS-1:0] d, input bit accepted);
      cfg_we     = 1'b1;
      cfg_router = 2'(r);
      cfg_addr   = DB'(a);
      cfg_data   = d;
      if (accepted) ref_mem[r][a] = d;
      else          err_q.push_back(cyc + 1);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic issue_start();
      int acc;
      ld_s    = cyc + 1;
      load_on = 1'b1;
      acc     = 0;
      for (int k = 0; k < ROUTERS; k++) begin
         rel_q.push_back('{k, ld_s + acc});
         acc += slot_len[k];
      end
      done_q.push_back(ld_s + acc);
      pulse_start();
   endtask

   task automatic wait_done();
      for (int i = 0; i < 3000; i++) begin
         if (done === 1'b1) break;
         @(negedge clk);
      end
      check("done_reached", done, 1'b1);
      repeat (2) @(negedge clk);
   endtask

   task automatic compare_tables();
      int nmis;
      for (int k = 0; k < ROUTERS; k++) begin
         if (!hold_low[k]) begin
            nmis = 0;
            for (int a = 0; a < DESTS; a++) if (cap[k][a] !== ref_mem[k][a]) nmis++;
            check($sformatf("table_mismatches_r%0d", k), nmis, 0);
         end
      end
   endtask

   task automatic apply_reset();
      reset   = 1'b1;
      load_on = 1'b0;
      rel_q.delete();
      done_q.delete();
      err_q.delete();
      #1;
      check("rst_rtr_reset", rtr_reset, 4'hF);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_cfg_err", cfg_err, 1'b0);
      check("rst_err_flags", err_flags, 4'h0);
      check("rst_table_data", rtr_table_data, '0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int gap;
      for (int k = 0; k < ROUTERS; k++) slot_len[k] = SLOT;
      repeat (2) @(negedge clk);
      apply_reset();

      // Deterministic pattern, full load, with a rejected write and an ignored start mid-load.
      for (int r = 0; r < ROUTERS; r++)
         for (int a = 0; a < DESTS; a++) cfg_write(r, a, PORT_BITS'((r * 16 + a) & 8'hFF), 1'b1);
      issue_start();
      repeat ($urandom_range(5, 60)) @(negedge clk);
      cfg_write(1, 5, 8'hAA, 1'b0);
      repeat ($urandom_range(5, 200)) @(negedge clk);
      pulse_start();
      wait_done();
      compare_tables();
      check("store_1_5_unchanged", cap[1][5], 8'h15);

      // DONE: writes rejected, start re-arms to IDLE with everyone back in reset.
      cfg_write(2, 7, 8'h55, 1'b0);
      pulse_start();
      check("rearm_rtr_reset", rtr_reset, 4'hF);
      check("rearm_done", done, 1'b0);
      repeat (3) @(negedge clk);
      check("idle_busy", busy, 1'b0);

      // Random rewrites, then reload.
      for (int i = 0; i < 40; i++)
         cfg_write($urandom_range(0, ROUTERS - 1), $urandom_range(0, DESTS - 1), PORT_BITS'($urandom), 1'b1);
      gap = $urandom_range(0, 5);
      repeat (gap) @(negedge clk);
      issue_start();
      wait_done();
      compare_tables();

      // Reset in the middle of a load, then a clean restart.
      pulse_start();
      issue_start();
      for (int i = 0; i < 400 && cyc < ld_s + 199; i++) @(negedge clk);
      apply_reset();
      for (int i = 0; i < 10; i++)
         cfg_write($urandom_range(0, ROUTERS - 1), $urandom_range(0, DESTS - 1), PORT_BITS'($urandom), 1'b1);
      issue_start();
      wait_done();
      compare_tables();
      check("err_flags_after_load", err_flags, 4'h0);

`ifdef TABLE_LOADER_TIMEOUT_EN
      // Router 2 never becomes ready: watchdog flags it and moves on to router 3.
      apply_reset();
      hold_low    = 4'b0100;
      slot_len[2] = DESTS + SLACK + 1;
      issue_start();
      wait_done();
      check("timeout_err_flags", err_flags, 4'b0100);
      check("timeout_router2_released", rtr_reset[2], 1'b0);
      compare_tables();
      pulse_start();
      check("err_flags_kept_on_rearm", err_flags, 4'b0100);
`endif

      repeat (3) @(negedge clk);
      check("release_queue_empty", rel_q.size(), 0);
      check("done_queue_empty", done_q.size(), 0);
      check("cfg_err_queue_empty", err_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

endmodule
